// File: rtl/mem_req_arb_pkg.sv
// rtl/mem_req_arb_pkg.sv - shared encodings for the memory request arbiter
package mem_req_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ID_I = 2'd0,
        ID_D = 2'd1,
        ID_N = 2'd2
    } req_id_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_req_arb_rr_pick3.sv
// rtl/mem_req_arb_rr_pick3.sv - combinational 3-way round-robin selector
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       any
);

    // Search starts at the requester after `last`; an out-of-range last behaves like 2.
    always_comb begin
        grant = 2'd0;
        any   = |req;
        case (last)
            2'd0: begin
                if (req[1])      grant = 2'd1;
                else if (req[2]) grant = 2'd2;
                else             grant = 2'd0;
            end
            2'd1: begin
                if (req[2])      grant = 2'd2;
                else if (req[0]) grant = 2'd0;
                else             grant = 2'd1;
            end
            default: begin
                if (req[0])      grant = 2'd0;
                else if (req[1]) grant = 2'd1;
                else             grant = 2'd2;
            end
        endcase
    end

endmodule

// File: rtl/mem_req_arb.sv
// rtl/mem_req_arb.sv - round-robin arbiter funnelling I/D/N requests into one
// serialised downstream channel with per-transaction timeout
module mem_req_arb
    import mem_req_arb_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               TIMEOUT  = 1024,
    parameter logic [WIDTH-1:0] ERR_DATA = WIDTH'(DEFAULT_ERR_DATA)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req_valid,
    input  logic [WIDTH-1:0]   i_req_addr,
    input  logic [WIDTH-1:0]   i_req_data,
    input  logic [WIDTH/8-1:0] i_req_mask,
    input  logic               d_req_valid,
    input  logic [WIDTH-1:0]   d_req_addr,
    input  logic [WIDTH-1:0]   d_req_data,
    input  logic [WIDTH/8-1:0] d_req_mask,
    input  logic               n_req_valid,
    input  logic [WIDTH-1:0]   n_req_addr,
    input  logic [WIDTH-1:0]   n_req_data,
    input  logic [WIDTH/8-1:0] n_req_mask,
    output logic               i_resp_valid,
    output logic [WIDTH-1:0]   i_resp_data,
    output logic               d_resp_valid,
    output logic [WIDTH-1:0]   d_resp_data,
    output logic               n_resp_valid,
    output logic [WIDTH-1:0]   n_resp_data,
    output logic               m_req_valid,
    output logic [WIDTH-1:0]   m_req_addr,
    output logic [WIDTH-1:0]   m_req_data,
    output logic [WIDTH/8-1:0] m_req_mask,
    input  logic               m_resp_valid,
    input  logic [WIDTH-1:0]   m_resp_data,
    output logic               busy,
    output logic               err_timeout
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state;
    state_t           next_state;
    req_id_t          last;
    req_id_t          gnt;
    logic [1:0]       pick_id;
    logic             pick_any;
    logic [CW-1:0]    cnt;
    logic             timeout_hit;
    logic             wait_done;
    logic [WIDTH-1:0] resp_word;

    rr_pick3 u_pick (
        .req   ({n_req_valid, d_req_valid, i_req_valid}),
        .last  (last),
        .grant (pick_id),
        .any   (pick_any)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_MAX);
    assign wait_done   = m_resp_valid || timeout_hit;
    assign resp_word   = m_resp_valid ? m_resp_data : ERR_DATA;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state   = state;
        m_req_valid  = 1'b0;
        busy         = 1'b1;
        i_resp_valid = 1'b0;
        d_resp_valid = 1'b0;
        n_resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (pick_any) next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                m_req_valid = 1'b1;
                next_state  = ST_WAIT;
            end
            ST_WAIT: begin
                m_req_valid = 1'b1;
                if (wait_done) next_state = ST_RESP;
            end
            default: begin
                i_resp_valid = (gnt == ID_I);
                d_resp_valid = (gnt == ID_D);
                n_resp_valid = (gnt == ID_N);
                next_state   = ST_IDLE;
            end
        endcase
    end

    // Response data is written into the originator's register on the way into RESP,
    // so the other ports' data registers keep their last values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last        <= ID_N;
            gnt         <= ID_I;
            m_req_addr  <= '0;
            m_req_data  <= '0;
            m_req_mask  <= '0;
            cnt         <= '0;
            err_timeout <= 1'b0;
            i_resp_data <= '0;
            d_resp_data <= '0;
            n_resp_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt  <= req_id_t'(pick_id);
                        last <= req_id_t'(pick_id);
                        case (pick_id)
                            2'd0: begin
                                m_req_addr <= i_req_addr;
                                m_req_data <= i_req_data;
                                m_req_mask <= i_req_mask;
                            end
                            2'd1: begin
                                m_req_addr <= d_req_addr;
                                m_req_data <= d_req_data;
                                m_req_mask <= d_req_mask;
                            end
                            default: begin
                                m_req_addr <= n_req_addr;
                                m_req_data <= n_req_data;
                                m_req_mask <= n_req_mask;
                            end
                        endcase
                    end
                end
                ST_ISSUE: cnt <= '0;
                ST_WAIT: begin
                    if (wait_done) begin
                        if (!m_resp_valid) err_timeout <= 1'b1;
                        case (gnt)
                            ID_I:    i_resp_data <= resp_word;
                            ID_D:    d_resp_data <= resp_word;
                            default: n_resp_data <= resp_word;
                        endcase
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
